// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the data-memory stream reader.
package mem_stream_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One stream beat as presented to the sink.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  // Pick byte idx of a word, byte 0 being the least significant.
  function automatic logic [7:0] byte_sel(input logic [31:0]           w,
                                          input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_stream_reader.sv
// Read-only memory bus initiator: walks a word region and streams it out
// as word beats or LSB-first byte beats over valid/ready.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_mode,
  output logic [31:0]      mem_a,
  output logic             mem_we,
  input  logic [31:0]      mem_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t                state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  byte_mode_q, byte_mode_d;
  logic [CNT_W-1:0]      word_idx_q, word_idx_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]           hold_q, hold_d;
  logic [31:0]           mem_a_q, mem_a_d;
  logic                  valid_q, valid_d;
  beat_t                 beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_word;
  logic [CNT_W-1:0]      word_idx_nxt;

  assign last_word    = (word_idx_q == count_q - CNT_W'(1));
  assign word_idx_nxt = word_idx_q + CNT_W'(1);

  // Next-state and next-output logic for the FETCH/SEND walk.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    byte_mode_d = byte_mode_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    hold_d      = hold_q;
    mem_a_d     = mem_a_q;
    valid_d     = valid_q;
    beat_d      = beat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d     = FETCH;
            base_d      = base_addr & ~32'h3;
            count_d     = word_count;
            byte_mode_d = byte_mode;
            word_idx_d  = '0;
            mem_a_d     = base_addr & ~32'h3;
            busy_d      = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      FETCH: begin
        hold_d      = mem_rd;
        byte_idx_d  = '0;
        state_d     = SEND;
        valid_d     = 1'b1;
        beat_d.data = byte_mode_q ? {24'h0, mem_rd[7:0]} : mem_rd;
        beat_d.last = last_word && !byte_mode_q;
      end

      SEND: begin
        if (out_ready) begin
          if (byte_mode_q && (byte_idx_q != '1)) begin
            byte_idx_d  = byte_idx_q + BYTE_IDX_W'(1);
            beat_d.data = {24'h0, byte_sel(hold_q, byte_idx_d)};
            beat_d.last = last_word && (byte_idx_d == '1);
          end else begin
            valid_d    = 1'b0;
            beat_d     = '0;
            word_idx_d = word_idx_nxt;
            if (last_word) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
              // Byte address arithmetic wraps naturally modulo 2^32.
              mem_a_d = base_q + 32'(WORD_BYTES) * 32'(word_idx_nxt);
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      byte_mode_q <= 1'b0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      hold_q      <= '0;
      mem_a_q     <= '0;
      valid_q     <= 1'b0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      byte_mode_q <= byte_mode_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      hold_q      <= hold_d;
      mem_a_q     <= mem_a_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_we    = 1'b0;
  assign out_valid = valid_q;
  assign out_data  = beat_q.data;
  assign out_last  = beat_q.last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: expected beats are queued from a
// memory model when a transfer is launched and popped on each handshake.
module tb_mem_stream_reader;
  import mem_stream_pkg::*;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             byte_mode;
  logic [31:0]      mem_a;
  logic             mem_we;
  logic [31:0]      mem_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];
  beat_t       exp_q[$];

  logic        stall_pending = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  logic        busy_seen  = 1'b0;
  logic        valid_seen = 1'b0;

  mem_stream_reader #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_mode  (byte_mode),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Combinational data memory, aliased over 64 words.
  assign mem_rd = mem[mem_a[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: compare beats on handshake and check hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (busy)      busy_seen  = 1'b1;
      if (out_valid) valid_seen = 1'b1;
      if (out_valid) begin
        if (stall_pending) begin
          check("stall data", out_data, stall_data);
          check("stall last", {31'h0, out_last}, {31'h0, stall_last});
        end
        stall_pending = !out_ready;
        stall_data    = out_data;
        stall_last    = out_last;
        if (out_ready) begin
          check("mem_we", {31'h0, mem_we}, 32'h0);
          if (exp_q.size() == 0) begin
            check("extra beat", 32'h1, 32'h0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat data", out_data, e.data);
            check("beat last", {31'h0, out_last}, {31'h0, e.last});
          end
        end
      end
    end
  end

  // Queue the beats a transfer is expected to produce, from the memory model.
  task automatic push_expected(input logic [31:0] base, input int cnt, input logic bm);
    for (int w = 0; w < cnt; w++) begin
      logic [31:0] word;
      logic [31:0] a;
      a    = (base & ~32'h3) + 32'(w * 4);
      word = mem[a[7:2]];
      if (bm) begin
        for (int b = 0; b < 4; b++) begin
          beat_t e;
          e.data = {24'h0, byte_sel(word, b[1:0])};
          e.last = (w == cnt - 1) && (b == 3);
          exp_q.push_back(e);
        end
      end else begin
        beat_t e;
        e.data = word;
        e.last = (w == cnt - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Launch a transfer and count edges after the accepting edge until done.
  // Called #1 after a posedge; returns #1 after the edge done was seen.
  task automatic run(input string tag, input logic [31:0] base, input int cnt,
                     input logic bm, input bit toggle, input bit inject,
                     output int edges);
    logic [3:0] pat;
    pat = 4'b1001;
    push_expected(base, cnt, bm);
    base_addr  = base;
    word_count = cnt[CNT_W-1:0];
    byte_mode  = bm;
    out_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    if (toggle) out_ready = pat[3];
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (inject && (edges == 1 || edges == 3)) begin
        start      = 1'b1;
        base_addr  = 32'h20;
        word_count = 9'd1;
      end
      if (toggle) out_ready = pat[3 - (edges % 4)];
    end
    start = 1'b0;
    check({tag, " done seen"}, {31'h0, done}, 32'h1);
    check({tag, " queue drained"}, exp_q.size(), 32'h0);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, {31'h0, done}, 32'h0);
    out_ready = 1'b1;
  endtask

  initial begin
    int edges;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h4444_4444;
    mem[4] = 32'h6C6C_6548;
    mem[8] = 32'hDEAD_BEEF;

    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_mode  = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_a",     mem_a, 32'h0);
    check("rst mem_we",    {31'h0, mem_we}, 32'h0);
    check("rst out_valid", {31'h0, out_valid}, 32'h0);
    check("rst out_data",  out_data, 32'h0);
    check("rst out_last",  {31'h0, out_last}, 32'h0);
    check("rst busy",      {31'h0, busy}, 32'h0);
    check("rst done",      {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: four words, ready high; done appears 8 edges after the accepting edge.
    run("t1", 32'h0, 4, 1'b0, 1'b0, 1'b0, edges);
    check("t1 latency", edges, 8);

    // 2: unaligned base in byte mode; address forced to the word boundary.
    push_expected(32'h12, 1, 1'b1);
    base_addr  = 32'h12;
    word_count = 9'd1;
    byte_mode  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t2 mem_a", mem_a, 32'h10);
    check("t2 busy",  {31'h0, busy}, 32'h1);
    edges = 0;
    while (!done && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    check("t2 done seen", {31'h0, done}, 32'h1);
    check("t2 latency", edges, 5);
    check("t2 queue drained", exp_q.size(), 32'h0);
    @(posedge clk); #1;

    // 3: ready toggling 1,0,0,1 stalls beats without loss or duplication.
    run("t3", 32'h0, 4, 1'b0, 1'b1, 1'b0, edges);

    // 4: zero-length transfer completes with no beats and no busy.
    busy_seen  = 1'b0;
    valid_seen = 1'b0;
    run("t4", 32'h40, 0, 1'b0, 1'b0, 1'b0, edges);
    check("t4 latency", edges, 0);
    check("t4 busy seen",  {31'h0, busy_seen}, 32'h0);
    check("t4 valid seen", {31'h0, valid_seen}, 32'h0);

    // 5: start pulses while busy are ignored.
    run("t5", 32'h0, 4, 1'b0, 1'b0, 1'b1, edges);
    check("t5 latency", edges, 8);

    // 6: reset in the middle of a 3-word transfer, then a clean restart.
    push_expected(32'h0, 3, 1'b0);
    base_addr  = 32'h0;
    word_count = 9'd3;
    byte_mode  = 1'b0;
    out_ready  = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("t6 reached send", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", {31'h0, out_valid}, 32'h0);
    check("t6 rst out_data",  out_data, 32'h0);
    check("t6 rst out_last",  {31'h0, out_last}, 32'h0);
    check("t6 rst mem_a",     mem_a, 32'h0);
    check("t6 rst busy",      {31'h0, busy}, 32'h0);
    check("t6 rst done",      {31'h0, done}, 32'h0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("t6", 32'h0, 2, 1'b0, 1'b0, 1'b0, edges);
    check("t6 latency", edges, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
